// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the receive, transmit and controller blocks.
package i2s_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int SCK_PER_FRAME      = 64;
  localparam int MCLK_PER_SCK       = 8;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // Left-channel words carry TLAST=1 on the stream side
  function automatic logic channel_is_left(input channel_e ch);
    return (ch == CH_LEFT);
  endfunction

endpackage

// File: rtl/i2s_rx_fifo.sv
// Small synchronous FIFO with registered head outputs. The head word is
// forwarded straight from the write port when the FIFO would otherwise be
// empty, so a push into an empty FIFO is visible one clock later.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module i2s_rx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic             head_fwd;

  // Accept/pop qualification and next-state pointers
  always_comb begin
    pop_ok     = pop & ~empty;
    push_ok    = push & (~full | pop_ok);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop_ok);
    count_nxt  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_fwd   = push_ok & (wr_ptr == rd_ptr_nxt);
  end

  // Storage array (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy flags and the registered head word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_ok);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CNT_W'(DEPTH));
      if (count_nxt != '0) dout <= head_fwd ? din : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/i2s_receive.sv
// I2S slave receiver: deserialises sd using mclk-synchronous sck/ws and
// emits one AXI4-Stream word per channel slot (TLAST=1 for left).
// Optional feature macro: I2S_RX_OVERFLOW_CNT_EN adds a saturating
// overflow_count output next to the sticky overflow flag.
module i2s_receive
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  overflow
`ifdef I2S_RX_OVERFLOW_CNT_EN
  ,
  output logic [15:0]           overflow_count
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

`ifdef I2S_RX_OVERFLOW_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic                  sck_q;
  logic                  sck_rise;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  bit_take;
  channel_e              ws_last;
  logic                  ws_edge;
  logic                  slot_end;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  last_p1;

  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  // ---- p0: sck edge detect and deserialiser ----

  // sck is sampled as data; a rise is the only cycle that consumes sd
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) sck_q <= 1'b0;
    else                 sck_q <= sck;
  end

  assign sck_rise = sck & ~sck_q;

  // Shift candidate: the bit is taken until the slot is full, then ignored
  always_comb begin
    bit_take  = (bit_cnt < CNT_W'(DATA_WIDTH));
    shift_nxt = bit_take ? {shift_q[DATA_WIDTH-2:0], sd} : shift_q;
    cnt_nxt   = bit_take ? bit_cnt + CNT_W'(1) : bit_cnt;
    ws_edge   = (channel_e'(ws) != ws_last);
    slot_end  = sck_rise & ws_edge;
  end

  // Shift register, bit counter and channel tracking; a ws change closes the slot
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      shift_q <= '0;
      bit_cnt <= '0;
      ws_last <= CH_LEFT;
    end else if (sck_rise) begin
      if (ws_edge) begin
        shift_q <= '0;
        bit_cnt <= '0;
        ws_last <= channel_e'(ws);
      end else begin
        shift_q <= shift_nxt;
        bit_cnt <= cnt_nxt;
      end
    end
  end

  // ---- p1: completed-slot register feeding the output buffer ----

  // Only a slot that collected every bit (LSB included) is handed on
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) vld_p1 <= 1'b0;
    else                 vld_p1 <= slot_end & (cnt_nxt == CNT_W'(DATA_WIDTH));
  end

  // Word and channel tag of the closing slot
  always_ff @(posedge M_AXIS_ACLK) begin
    if (slot_end) begin
      data_p1 <= shift_nxt;
      last_p1 <= channel_is_left(ws_last);
    end
  end

  // ---- p2: output buffer and AXI4-Stream master ----

  assign pop  = M_AXIS_TVALID & M_AXIS_TREADY;
  assign drop = vld_p1 & fifo_full & ~pop;

  i2s_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .push  (vld_p1),
    .din   ({last_p1, data_p1}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign M_AXIS_TVALID = ~fifo_empty;
  assign M_AXIS_TDATA  = fifo_dout[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = fifo_dout[DATA_WIDTH];

  // Sticky flag: set by any word lost to a full buffer
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) overflow <= 1'b0;
    else if (drop)       overflow <= 1'b1;
  end

`ifdef I2S_RX_OVERFLOW_CNT_EN
  // Dropped-word counter, holds at all-ones
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) overflow_count <= '0;
    else if (drop)       overflow_count <= sat_inc16(overflow_count);
  end
`endif

endmodule

// File: tb/tb_i2s_receive.sv
// Self-checking bench for i2s_receive: a serial I2S source (ws/sd change
// while sck is low, sd lagging ws by one bit) plus a word-level model of
// which slots must appear on the stream and in what order.
module tb_i2s_receive;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sck, ws, sd;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast, overflow;
`ifdef I2S_RX_OVERFLOW_CNT_EN
  logic [15:0]   ovf_cnt;
`endif

  int            n_checks = 0;
  int            n_pass   = 0;
  logic          sd_dly   = 1'b0;
  logic [DW:0]   expq[$];
  bit            drv_done;

  always #5 clk = ~clk;

  i2s_receive #(.DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .sck            (sck),
    .ws             (ws),
    .sd             (sd),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TREADY  (tready),
    .M_AXIS_TLAST   (tlast),
    .overflow       (overflow)
`ifdef I2S_RX_OVERFLOW_CNT_EN
    ,
    .overflow_count (ovf_cnt)
`endif
  );

  // One sck period of 8 mclk: falling edge drives ws and the delayed bit
  task automatic sck_cycle(input logic ws_v, input logic b);
    @(posedge clk); #1;
    sck = 1'b0; ws = ws_v; sd = sd_dly; sd_dly = b;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // One 32-bit slot, MSB first; optional reset release / assertion before a bit
  task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int rel_bit, input int asrt_bit);
    for (int i = 0; i < DW; i++) begin
      if (i == rel_bit)  begin #2 rst_n = 1'b1; end
      if (i == asrt_bit) begin #2 rst_n = 1'b0; end
      sck_cycle(ch, w[DW-1-i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0; tready = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (tdata !== '0)    $display("FAIL reset_tdata got=%h exp=0", tdata);    else n_pass++;
    n_checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", tvalid);  else n_pass++;
    n_checks++; if (tlast !== 1'b0)  $display("FAIL reset_tlast got=%b exp=0", tlast);    else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
`ifdef I2S_RX_OVERFLOW_CNT_EN
    n_checks++; if (ovf_cnt !== 16'd0) $display("FAIL reset_ovf_cnt got=%h exp=0", ovf_cnt); else n_pass++;
`endif
  endtask

  // Reset released mid-left slot: partial slot dropped, following slots in order
  task automatic test_first_slot();
    logic [DW:0] e;
    int cyc;
    expq.delete();
    rst_n = 1'b0; tready = 1'b1; drv_done = 1'b0;
    repeat (3) @(posedge clk);
    expq.push_back({1'b0, 32'h0F0F_F0F0});
    expq.push_back({1'b1, 32'hA5A5_0001});
    expq.push_back({1'b0, 32'h5A5A_0002});
    fork
      begin
        send_slot(1'b0, 32'hFFFF_FFFF, 9, -1);
        send_slot(1'b1, 32'h0F0F_F0F0, -1, -1);
        send_slot(1'b0, 32'hA5A5_0001, -1, -1);
        send_slot(1'b1, 32'h5A5A_0002, -1, -1);
        send_slot(1'b0, 32'h0000_0000, -1, -1);
        drv_done = 1'b1;
      end
      begin
        cyc = 0;
        while (cyc < 20000 && !(drv_done && expq.size() == 0)) begin
          @(negedge clk); cyc++;
          if (tvalid && tready) begin
            n_checks++;
            if (expq.size() == 0) $display("FAIL first_extra got=%b/%h exp=none", tlast, tdata);
            else begin
              e = expq.pop_front();
              if ({tlast, tdata} !== e) $display("FAIL first_word got=%b/%h exp=%b/%h", tlast, tdata, e[DW], e[DW-1:0]);
              else n_pass++;
            end
          end
        end
      end
    join
    n_checks++; if (expq.size() != 0) $display("FAIL first_missing got=%0d left exp=0", expq.size()); else n_pass++;
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b0) $display("FAIL first_idle_tvalid got=%b exp=0", tvalid); else n_pass++;
  endtask

  // TVALID rises exactly 2 mclk after the sck rise that carries the LSB
  task automatic test_latency();
    logic [DW-1:0] w;
    w = $urandom;
    rst_n = 1'b0; tready = 1'b0;
    repeat (3) @(posedge clk);
    send_slot(1'b0, 32'h1357_9BDF, 12, -1);
    send_slot(1'b1, w, -1, -1);
    @(posedge clk); #1;
    sck = 1'b0; ws = 1'b0; sd = sd_dly; sd_dly = 1'b0;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (tvalid !== 1'b0) $display("FAIL lat_early got=%b exp=0", tvalid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (tvalid !== 1'b1) $display("FAIL lat_valid got=%b exp=1", tvalid); else n_pass++;
    n_checks++; if ({tlast, tdata} !== {1'b0, w}) $display("FAIL lat_word got=%b/%h exp=0/%h", tlast, tdata, w); else n_pass++;
    @(posedge clk);
  endtask

  // Random words with random backpressure: stream equals the sent slots
  task automatic test_random();
    logic [DW-1:0] words[10];
    logic [DW:0]   e;
    int cyc;
    expq.delete();
    rst_n = 1'b0; tready = 1'b1; drv_done = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      words[i] = $urandom;
      expq.push_back({(i % 2 == 1), words[i]});
    end
    fork
      begin
        send_slot(1'b0, $urandom, int'($urandom_range(4, 24)), -1);
        for (int i = 0; i < 10; i++) send_slot((i % 2 == 0), words[i], -1, -1);
        send_slot(1'b1, $urandom, -1, -1);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
        end
        tready = 1'b1;
      end
      begin
        cyc = 0;
        while (cyc < 40000 && !(drv_done && expq.size() == 0)) begin
          @(negedge clk); cyc++;
          if (tvalid && tready) begin
            n_checks++;
            if (expq.size() == 0) $display("FAIL rand_extra got=%b/%h exp=none", tlast, tdata);
            else begin
              e = expq.pop_front();
              if ({tlast, tdata} !== e) $display("FAIL rand_word got=%b/%h exp=%b/%h", tlast, tdata, e[DW], e[DW-1:0]);
              else n_pass++;
            end
          end
        end
      end
    join
    n_checks++; if (expq.size() != 0) $display("FAIL rand_missing got=%0d left exp=0", expq.size()); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rand_overflow got=%b exp=0", overflow); else n_pass++;
  endtask

  // Buffer full, third word dropped, held words stable then drained in order
  task automatic test_overflow();
    logic [DW-1:0] w1, w2, w3;
    w1 = $urandom; w2 = $urandom; w3 = $urandom;
    rst_n = 1'b0; tready = 1'b0;
    repeat (3) @(posedge clk);
    send_slot(1'b0, $urandom, 15, -1);
    send_slot(1'b1, w1, -1, -1);
    send_slot(1'b0, w2, -1, -1);
    #1;
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b10, w1}) $display("FAIL ovf_hold1 got=%b%b/%h exp=10/%h", tvalid, tlast, tdata, w1); else n_pass++;
    send_slot(1'b1, w3, -1, -1);
    #1;
    n_checks++; if ({overflow, tdata} !== {1'b0, w1}) $display("FAIL ovf_hold2 got=%b/%h exp=0/%h", overflow, tdata, w1); else n_pass++;
    send_slot(1'b0, $urandom, -1, -1);
    #1;
    n_checks++; if ({overflow, tdata} !== {1'b1, w1}) $display("FAIL ovf_flag got=%b/%h exp=1/%h", overflow, tdata, w1); else n_pass++;
`ifdef I2S_RX_OVERFLOW_CNT_EN
    n_checks++; if (ovf_cnt !== 16'd1) $display("FAIL ovf_count got=%0d exp=1", ovf_cnt); else n_pass++;
`endif
    @(posedge clk); #1 tready = 1'b1;
    @(negedge clk);
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b10, w1}) $display("FAIL ovf_drain1 got=%b%b/%h exp=10/%h", tvalid, tlast, tdata, w1); else n_pass++;
    @(negedge clk);
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b11, w2}) $display("FAIL ovf_drain2 got=%b%b/%h exp=11/%h", tvalid, tlast, tdata, w2); else n_pass++;
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b0) $display("FAIL ovf_drain_end got=%b exp=0", tvalid); else n_pass++;
    tready = 1'b0;
  endtask

  // Full buffer with a pop in the very cycle the new word arrives: nothing lost
  task automatic test_push_pop_full();
    logic [DW-1:0] w1, w2, w3;
    w1 = $urandom; w2 = $urandom; w3 = $urandom;
    rst_n = 1'b0; tready = 1'b0;
    repeat (3) @(posedge clk);
    send_slot(1'b0, $urandom, 6, -1);
    send_slot(1'b1, w1, -1, -1);
    send_slot(1'b0, w2, -1, -1);
    send_slot(1'b1, w3, -1, -1);
    @(posedge clk); #1;
    sck = 1'b0; ws = 1'b0; sd = sd_dly; sd_dly = 1'b0;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    @(posedge clk); #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL pp_overflow got=%b exp=0", overflow); else n_pass++;
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b11, w2}) $display("FAIL pp_head got=%b%b/%h exp=11/%h", tvalid, tlast, tdata, w2); else n_pass++;
    @(posedge clk); #1 tready = 1'b1;
    @(negedge clk);
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b11, w2}) $display("FAIL pp_drain1 got=%b%b/%h exp=11/%h", tvalid, tlast, tdata, w2); else n_pass++;
    @(negedge clk);
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b10, w3}) $display("FAIL pp_drain2 got=%b%b/%h exp=10/%h", tvalid, tlast, tdata, w3); else n_pass++;
    @(negedge clk);
    n_checks++; if ({tvalid, overflow} !== 2'b00) $display("FAIL pp_end got=%b%b exp=00", tvalid, overflow); else n_pass++;
    tready = 1'b0;
  endtask

  // Async reset mid-slot clears outputs at once; first word afterwards is a complete slot
  task automatic test_reset_mid();
    logic [DW-1:0] wd, we;
    wd = $urandom; we = $urandom;
    rst_n = 1'b0; tready = 1'b0;
    repeat (3) @(posedge clk);
    send_slot(1'b0, $urandom, 7, -1);
    send_slot(1'b1, 32'hDEAD_BEEF, -1, -1);
    send_slot(1'b0, 32'hCAFE_F00D, -1, -1);
    send_slot(1'b1, $urandom, -1, -1);
    #1;
    n_checks++; if (tvalid !== 1'b1) $display("FAIL rmid_pre_tvalid got=%b exp=1", tvalid); else n_pass++;
    fork
      send_slot(1'b0, $urandom, 20, 11);
      begin
        @(negedge rst_n); #1;
        n_checks++; if ({tvalid, tlast, tdata} !== {2'b00, 32'h0}) $display("FAIL rmid_clear got=%b%b/%h exp=00/0", tvalid, tlast, tdata); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rmid_ovf got=%b exp=0", overflow); else n_pass++;
      end
    join
    send_slot(1'b1, wd, -1, -1);
    send_slot(1'b0, we, -1, -1);
    send_slot(1'b1, $urandom, -1, -1);
    @(posedge clk); #1 tready = 1'b1;
    @(negedge clk);
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b10, wd}) $display("FAIL rmid_word1 got=%b%b/%h exp=10/%h", tvalid, tlast, tdata, wd); else n_pass++;
    @(negedge clk);
    n_checks++; if ({tvalid, tlast, tdata} !== {2'b11, we}) $display("FAIL rmid_word2 got=%b%b/%h exp=11/%h", tvalid, tlast, tdata, we); else n_pass++;
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b0) $display("FAIL rmid_end got=%b exp=0", tvalid); else n_pass++;
    tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_latency();
    test_random();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
